instruction_sequencer: RTL

//  Front end of the GPU. Fetches 16-bit opcodes from a synchronous program memory and

---
 rtl/instruction_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Front end of the GPU. Fetches 16-bit opcodes from a synchronous program
//   memory and broadcasts them to every core on the opcode/execute bus. Owns
//   the 16-entry global register file. Control-flow ops (HALT, JUMP, LOOP,
//   SETLOOP) are consumed here and never broadcast.
//
//   Optional feature macro: SEQ_LOOP_EN
//     defined   : LOOP/SETLOOP use an 8-bit loop counter
//     undefined : no loop counter; LOOP/SETLOOP behave as NOPs (pc++)
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   start program at address 0 (ignored while busy)
//   abort                   synchronous stop back to IDLE, no done pulse
//   busy                    high while fetching/issuing
//   done                    one-cycle pulse after HALT executes
//   mem_en, mem_addr        program memory read request (address = pc)
//   mem_rdata               program memory data, valid one cycle after mem_en
//   gr_we, gr_addr, gr_wdata  host write port of the global register file
//   opcode, execute         broadcast opcode and its one-cycle strobe
//   global_registers_out    reg y at [BIT_WIDTH*(y+1)-1 : BIT_WIDTH*y]
module instruction_sequencer #(
  parameter int BIT_WIDTH       = 8,
  parameter int PROG_ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_en,
  output logic [PROG_ADDR_WIDTH-1:0]   mem_addr,
  input  logic [15:0]                  mem_rdata,
  input  logic                         gr_we,
  input  logic [3:0]                   gr_addr,
  input  logic [BIT_WIDTH-1:0]         gr_wdata,
  output logic [15:0]                  opcode,
  output logic                         execute,
  output logic [16*BIT_WIDTH-1:0]      global_registers_out
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_ISSUE = 2'b10;

  localparam logic [1:0] OP_HALT    = 2'b00;
  localparam logic [1:0] OP_JUMP    = 2'b01;
  localparam logic [1:0] OP_LOOP    = 2'b10;
  localparam logic [1:0] OP_SETLOOP = 2'b11;

  localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE = PROG_ADDR_WIDTH'(1);

  logic [1:0]                 state;
  logic [PROG_ADDR_WIDTH-1:0] pc;
  logic [PROG_ADDR_WIDTH-1:0] pc_inc;
  logic [PROG_ADDR_WIDTH-1:0] target;
  logic                       seq_op;
  logic [1:0]                 sub_op;
  logic                       issue;
  logic                       loop_taken;
  logic [BIT_WIDTH-1:0]       gregs [16];

  // Decode of the word returned for the current ISSUE cycle.
  always_comb begin
    seq_op = (mem_rdata[15:14] == 2'b11) && !mem_rdata[8];
    sub_op = mem_rdata[13:12];
    target = mem_rdata[PROG_ADDR_WIDTH-1:0];
    pc_inc = pc + PC_ONE;
  end

  // abort wins over decode, so side effects of the issuing word are gated here.
  assign issue = (state == S_ISSUE) && !abort;

`ifdef SEQ_LOOP_EN
  logic [7:0] loop_cnt;

  assign loop_taken = (loop_cnt > 8'd1);

  // Survives abort and program end; only reset, LOOP and SETLOOP change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_cnt <= '0;
    end else if (issue && seq_op) begin
      if (sub_op == OP_LOOP) begin
        loop_cnt <= loop_taken ? (loop_cnt - 8'd1) : '0;
      end else if (sub_op == OP_SETLOOP) begin
        loop_cnt <= mem_rdata[7:0];
      end
    end
  end
`else
  assign loop_taken = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      opcode  <= '0;
      execute <= 1'b0;
      done    <= 1'b0;
    end else begin
      execute <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        pc    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) state <= S_FETCH;
          end
          S_FETCH: begin
            state <= S_ISSUE;
          end
          S_ISSUE: begin
            state <= S_FETCH;
            pc    <= pc_inc;
            if (seq_op) begin
              case (sub_op)
                OP_HALT: begin
                  state <= S_IDLE;
                  pc    <= '0;
                  done  <= 1'b1;
                end
                OP_JUMP:    pc <= target;
                OP_LOOP:    pc <= loop_taken ? target : pc_inc;
                OP_SETLOOP: pc <= pc_inc;
                default:    pc <= pc_inc;
              endcase
            end else begin
              opcode  <= mem_rdata;
              execute <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy     = (state == S_FETCH) || (state == S_ISSUE);
  assign mem_en   = (state == S_FETCH);
  assign mem_addr = pc;

  // Host writes land on the next edge regardless of sequencer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) gregs[i] <= '0;
    end else if (gr_we) begin
      gregs[gr_addr] <= gr_wdata;
    end
  end

  always_comb begin
    global_registers_out = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      global_registers_out[BIT_WIDTH*i +: BIT_WIDTH] = gregs[i];
    end
  end

endmodule
